memory: RTL and testbench



---
 rtl/memory_if.sv | 26 ++
 rtl/memory.sv | 122 ++++++++++++
 tb/tb_memory.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/memory_if.sv
// Handshake bundle between a requester and the single-port memory.
// clk/rst ride along so checkers and masters can sample from one handle.
interface mem_intrf #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 5
) (
    input logic clk,
    input logic rst
);
    logic                  wr_rd;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      wdata;
    logic                  valid;
    logic                  ready;
    logic [WIDTH-1:0]      rdata;

    modport design_mp (
        input  clk, rst, wr_rd, addr, wdata, valid,
        output rdata, ready
    );

    modport master_mp (
        input  clk, rst, rdata, ready,
        output wr_rd, addr, wdata, valid
    );
endinterface

// File: rtl/memory.sv
// Single-port RAM, one read or write per valid&ready edge; read data registered (1 cycle).
// No wait states: ready is low only for reset cycles and the edge after, then held high.
module memory #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 5
) (
    input logic        clk,
    input logic        rst,
    mem_intrf.design_mp bus
);
    typedef enum logic {
        ST_RESET = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic             accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // ready comes straight from the state register, so it is glitch-free and
    // stays low for exactly one edge after reset releases.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET: state_d = ST_RUN;
            ST_RUN:   state_d = ST_RUN;
            default:  state_d = ST_RESET;
        endcase
    end

    assign bus.ready = (state_q == ST_RUN);
    assign accept    = bus.valid && bus.ready;

    // Reset clears the array too, so contents read as zero after any reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata_q <= '0;
        end else if (accept) begin
            if (bus.wr_rd) begin
                mem[bus.addr] <= bus.wdata;
            end else begin
                rdata_q <= mem[bus.addr];
            end
        end
    end

    assign bus.rdata = rdata_q;

    mem_assert #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem_assert (
        .clk  (clk),
        .rst  (rst),
        .wr_rd(bus.wr_rd),
        .addr (bus.addr),
        .wdata(bus.wdata),
        .valid(bus.valid),
        .ready(bus.ready),
        .rdata(bus.rdata)
    );
endmodule

// Protocol checker: watches the handshake and keeps its own shadow copy of the
// array to confirm each accepted read returns the last data written there.
module mem_assert #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 5
) (
    input logic                  clk,
    input logic                  rst,
    input logic                  wr_rd,
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [WIDTH-1:0]      wdata,
    input logic                  valid,
    input logic                  ready,
    input logic [WIDTH-1:0]      rdata
);
    logic [WIDTH-1:0] shadow [DEPTH];
    logic [WIDTH-1:0] exp_q;
    logic             exp_vld;
    logic             rst_seen;

    always_ff @(posedge clk) begin
        rst_seen <= rst_seen | rst;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                shadow[i] <= '0;
            end
            exp_vld <= 1'b0;
            exp_q   <= '0;
        end else begin
            exp_vld <= valid && ready && !wr_rd;
            exp_q   <= shadow[addr];
            if (valid && ready && wr_rd) begin
                shadow[addr] <= wdata;
            end
        end
    end

    a_req_known: assert property (@(posedge clk) (!rst && valid) |-> !$isunknown({wr_rd, addr}));
    a_wdata_known: assert property (@(posedge clk) (valid && wr_rd) |-> !$isunknown(wdata));
    a_reset_out: assert property (@(posedge clk) rst |=> (rdata == '0 && !ready));
    a_ready_known: assert property (@(posedge clk) rst_seen |-> !$isunknown(ready));
    a_read_data: assert property (@(posedge clk) exp_vld |-> (rdata == exp_q));
endmodule

// File: tb/tb_memory.sv
// Directed bench for memory: hand-computed expectations checked with immediate assertions.
module tb_memory;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

    mem_intrf #(.WIDTH(16), .ADDR_WIDTH(5)) bus_if (.clk(clk), .rst(rst));

    memory #(.WIDTH(16), .DEPTH(32), .ADDR_WIDTH(5)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic [4:0] a, input logic [15:0] d);
        bus_if.valid = v;
        bus_if.wr_rd = w;
        bus_if.addr  = a;
        bus_if.wdata = d;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst    = 1'b1;
        drive(1'b0, 1'b0, 5'd0, 16'h0000);

        // 1. reset, release, zero sweep
        tick();
        chk("rst_ready_0", {15'd0, bus_if.ready}, 16'h0000);
        chk("rst_rdata_0", bus_if.rdata, 16'h0000);
        tick();
        chk("rst_ready_1", {15'd0, bus_if.ready}, 16'h0000);
        chk("rst_rdata_1", bus_if.rdata, 16'h0000);
        rst = 1'b0;
        tick();
        chk("ready_after_release", {15'd0, bus_if.ready}, 16'h0001);
        for (int k = 0; k < 32; k++) begin
            drive(1'b1, 1'b0, 5'(k), 16'h0000);
            tick();
            chk($sformatf("zero_rd_%0d", k), bus_if.rdata, 16'h0000);
        end

        // 2. single write then read
        drive(1'b1, 1'b1, 5'd5, 16'hA5A5);
        tick();
        chk("wr5_rdata_hold", bus_if.rdata, 16'h0000);
        drive(1'b1, 1'b0, 5'd5, 16'h0000);
        tick();
        chk("rd5", bus_if.rdata, 16'hA5A5);

        // 3. full sweep, back-to-back
        for (int k = 0; k < 32; k++) begin
            drive(1'b1, 1'b1, 5'(k), 16'h1000 + 16'(k));
            tick();
        end
        chk("sweep_wr_rdata_hold", bus_if.rdata, 16'hA5A5);
        for (int k = 0; k < 32; k++) begin
            drive(1'b1, 1'b0, 5'(k), 16'h0000);
            tick();
            chk($sformatf("sweep_rd_%0d", k), bus_if.rdata, 16'h1000 + 16'(k));
        end

        // 4. idle hold with random non-accepted traffic
        drive(1'b1, 1'b1, 5'd9, 16'h00FF);
        tick();
        drive(1'b1, 1'b0, 5'd9, 16'h0000);
        tick();
        chk("rd9_ff", bus_if.rdata, 16'h00FF);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 16'($urandom));
            tick();
            chk($sformatf("idle_hold_%0d", i), bus_if.rdata, 16'h00FF);
        end
        drive(1'b1, 1'b0, 5'd20, 16'h0000);
        tick();
        chk("idle_rd20", bus_if.rdata, 16'h1014);
        drive(1'b1, 1'b0, 5'd9, 16'h0000);
        tick();
        chk("idle_rd9", bus_if.rdata, 16'h00FF);

        // 5. overwrite back-to-back, then read
        drive(1'b1, 1'b1, 5'd3, 16'h1111);
        tick();
        drive(1'b1, 1'b1, 5'd3, 16'h2222);
        tick();
        drive(1'b1, 1'b0, 5'd3, 16'h0000);
        tick();
        chk("rd3_overwrite", bus_if.rdata, 16'h2222);
        drive(1'b1, 1'b0, 5'd4, 16'h0000);
        tick();
        chk("rd4_neighbour", bus_if.rdata, 16'h1004);

        // 6. reset in the middle of a valid write
        drive(1'b1, 1'b1, 5'd7, 16'hBEEF);
        tick();
        drive(1'b1, 1'b1, 5'd8, 16'hCAFE);
        rst = 1'b1;
        tick();
        chk("midrst_ready", {15'd0, bus_if.ready}, 16'h0000);
        chk("midrst_rdata", bus_if.rdata, 16'h0000);
        rst = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 16'h0000);
        tick();
        chk("midrst_ready_back", {15'd0, bus_if.ready}, 16'h0001);
        drive(1'b1, 1'b1, 5'd10, 16'h1234);
        tick();
        drive(1'b1, 1'b0, 5'd10, 16'h0000);
        tick();
        chk("post_rst_rd10", bus_if.rdata, 16'h1234);
        drive(1'b1, 1'b0, 5'd7, 16'h0000);
        tick();
        chk("post_rst_rd7", bus_if.rdata, 16'h0000);
        drive(1'b1, 1'b1, 5'd11, 16'h5678);
        tick();
        drive(1'b1, 1'b0, 5'd11, 16'h0000);
        tick();
        chk("post_rst_rd11", bus_if.rdata, 16'h5678);
        drive(1'b1, 1'b0, 5'd8, 16'h0000);
        tick();
        chk("post_rst_rd8", bus_if.rdata, 16'h0000);
        drive(1'b0, 1'b0, 5'd0, 16'h0000);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
